// File: rtl/button_event_pkg.sv
// Shared types and constants for the button event classifier.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package button_event_pkg;

  // Width of the millisecond counter; it saturates at all-ones.
  localparam int MS_W = 16;
  localparam logic [MS_W-1:0] MS_MAX = '1;

  // Classifier states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DOWN1 = 3'd1,
    ST_UP1   = 3'd2,
    ST_DOWN2 = 3'd3,
    ST_LONG  = 3'd4
  } state_t;

  // Classified event bundle; at most one bit is set in any cycle.
  typedef struct packed {
    logic short_click;
    logic double_click;
    logic long_press;
    logic repeat_evt;
  } evt_t;

  // Clamp a millisecond threshold into the counter range so an oversized
  // parameter still compares against a reachable value.
  function automatic logic [MS_W-1:0] ms_limit(input int unsigned v);
    if (v > 32'(MS_MAX)) begin
      return MS_MAX;
    end
    return MS_W'(v);
  endfunction

endpackage

// File: rtl/button_tick_gen.sv
// Free-running 1 ms timebase: one-cycle tick every TICK_DIV clocks.
// Latency: tick is registered, high in the cycle after the counter wraps.
// Backpressure: none; runs continuously and is never cleared by the classifier.
module button_tick_gen #(
  parameter int unsigned TICK_DIV = 50000
) (
  input  logic clock,
  input  logic reset_n,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  // Count 0..TICK_DIV-1 and flag the wrap as a registered tick.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= (cnt == LAST);
      if (cnt == LAST) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/button_event.sv
// Classifies a debounced button into press/release edges and click/long/repeat events.
// Latency: every output is registered, one cycle after the causing input or timeout.
// Backpressure: none; pulses are one cycle wide and must be consumed when seen.
module button_event
  import button_event_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 50000,
  parameter int unsigned LONG_MS   = 800,
  parameter int unsigned DCLICK_MS = 250,
  parameter int unsigned REPEAT_MS = 100
) (
  input  logic clock,
  input  logic reset_n,
  input  logic btn_db,
  output logic held,
  output logic press,
  output logic release_pulse,
  output logic short_click,
  output logic double_click,
  output logic long_press,
  output logic repeat_pulse
);

  localparam logic [MS_W-1:0] LONG_LIM   = ms_limit(LONG_MS);
  localparam logic [MS_W-1:0] DCLICK_LIM = ms_limit(DCLICK_MS);
  localparam logic [MS_W-1:0] REPEAT_LIM = ms_limit(REPEAT_MS);

  logic            btn_prev;
  logic            rise;
  logic            fall;
  logic            tick;
  logic [MS_W-1:0] ms;
  logic            ms_clr;
  logic            rpt_clr;
  state_t          state;
  state_t          state_nxt;
  evt_t            evt_nxt;
  evt_t            evt_q;

  button_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clock  (clock),
    .reset_n(reset_n),
    .tick   (tick)
  );

  // Edges are seen against last cycle's sampled level.
  assign rise = btn_db & ~btn_prev;
  assign fall = ~btn_db & btn_prev;

  // Sample the level and register the edge pulses alongside it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      btn_prev      <= 1'b0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      btn_prev      <= btn_db;
      press         <= rise;
      release_pulse <= fall;
    end
  end

  assign held = btn_prev;

  // Next state and event; an edge always takes priority over a timeout.
  always_comb begin
    state_nxt = state;
    evt_nxt   = '0;
    rpt_clr   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rise) begin
          state_nxt = ST_DOWN1;
        end
      end
      ST_DOWN1: begin
        if (fall) begin
          state_nxt = ST_UP1;
        end else if (ms == LONG_LIM) begin
          state_nxt          = ST_LONG;
          evt_nxt.long_press = 1'b1;
        end
      end
      ST_UP1: begin
        if (rise) begin
          state_nxt            = ST_DOWN2;
          evt_nxt.double_click = 1'b1;
        end else if (ms == DCLICK_LIM) begin
          state_nxt           = ST_IDLE;
          evt_nxt.short_click = 1'b1;
        end
      end
      ST_DOWN2: begin
        // Second press of a double click is already reported; just wait it out.
        if (fall) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_LONG: begin
        if (fall) begin
          state_nxt = ST_IDLE;
        end else if (ms == REPEAT_LIM) begin
          evt_nxt.repeat_evt = 1'b1;
          rpt_clr            = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
    ms_clr = (state_nxt != state) || rpt_clr;
  end

  // Millisecond counter: restart on any state change or repeat, else count ticks.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ms <= '0;
    end else if (ms_clr) begin
      ms <= '0;
    end else if (tick && (ms != MS_MAX)) begin
      ms <= ms + MS_W'(1);
    end
  end

  // State register and registered event pulses.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      evt_q <= '0;
    end else begin
      state <= state_nxt;
      evt_q <= evt_nxt;
    end
  end

  assign short_click  = evt_q.short_click;
  assign double_click = evt_q.double_click;
  assign long_press   = evt_q.long_press;
  assign repeat_pulse = evt_q.repeat_evt;

endmodule

// File: tb/tb_button_event.sv
// Directed bench for button_event with a cycle-level reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_button_event;

  localparam int TDIV = 4;
  localparam int LMS  = 10;
  localparam int DMS  = 5;
  localparam int RMS  = 3;

  localparam int M_IDLE  = 0;
  localparam int M_DOWN1 = 1;
  localparam int M_UP1   = 2;
  localparam int M_DOWN2 = 3;
  localparam int M_LONG  = 4;

  logic clock;
  logic reset_n;
  logic btn_db;
  logic held, press, release_pulse, short_click, double_click, long_press, repeat_pulse;

  int total = 0;
  int bad   = 0;
  logic chk_en;

  button_event #(
    .TICK_DIV (TDIV),
    .LONG_MS  (LMS),
    .DCLICK_MS(DMS),
    .REPEAT_MS(RMS)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .btn_db       (btn_db),
    .held         (held),
    .press        (press),
    .release_pulse(release_pulse),
    .short_click  (short_click),
    .double_click (double_click),
    .long_press   (long_press),
    .repeat_pulse (repeat_pulse)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  logic [6:0] dut_vec;
  assign dut_vec = {held, press, release_pulse, short_click, double_click, long_press, repeat_pulse};

  task automatic chk(input string name, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, want, $time);
    end
  endtask

  // Reference model: time is measured as clock edges since reset; the ms value
  // is the number of 1 ms ticks elapsed since the last restart point.
  int   m_edges = 0;
  int   m_ticks = 0;
  int   m_mark  = 0;
  int   m_mode  = M_IDLE;
  logic m_prev  = 1'b0;
  logic [6:0] exp_vec = '0;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_edges = 0;
      m_ticks = 0;
      m_mark  = 0;
      m_mode  = M_IDLE;
      m_prev  = 1'b0;
      exp_vec = '0;
    end else begin
      int   ms_now;
      int   nmode;
      logic rse, fll, tick_now, restart;
      logic e_s, e_d, e_l, e_r;
      tick_now = (m_edges > 0) && (m_edges % TDIV == 0);
      ms_now   = m_ticks - m_mark;
      if (ms_now > 65535) ms_now = 65535;
      rse = btn_db && !m_prev;
      fll = !btn_db && m_prev;
      e_s = 0; e_d = 0; e_l = 0; e_r = 0;
      restart = 0;
      nmode = m_mode;
      if (m_mode == M_IDLE && rse) nmode = M_DOWN1;
      else if (m_mode == M_DOWN1) begin
        if (fll) nmode = M_UP1;
        else if (ms_now == LMS) begin nmode = M_LONG; e_l = 1; end
      end else if (m_mode == M_UP1) begin
        if (rse) begin nmode = M_DOWN2; e_d = 1; end
        else if (ms_now == DMS) begin nmode = M_IDLE; e_s = 1; end
      end else if (m_mode == M_DOWN2 && fll) nmode = M_IDLE;
      else if (m_mode == M_LONG) begin
        if (fll) nmode = M_IDLE;
        else if (ms_now == RMS) begin e_r = 1; restart = 1; end
      end
      if (tick_now) m_ticks = m_ticks + 1;
      if (nmode != m_mode || restart) m_mark = m_ticks;
      m_mode  = nmode;
      exp_vec = {btn_db, rse, fll, e_s, e_d, e_l, e_r};
      m_prev  = btn_db;
      m_edges = m_edges + 1;
    end
  end

  // Event log of the DUT, indexed press, release, short, double, long, repeat.
  int first_at[6];
  int n_evt[6];
  logic [5:0] ev;
  assign ev = {repeat_pulse, long_press, double_click, short_click, release_pulse, press};

  always @(negedge clock) begin
    if (chk_en) chk("outs", int'(dut_vec), int'(exp_vec));
    for (int i = 0; i < 6; i++) begin
      if (ev[i]) begin
        if (n_evt[i] == 0) first_at[i] = m_edges;
        n_evt[i] = n_evt[i] + 1;
      end
    end
  end

  task automatic clear_log;
    for (int i = 0; i < 6; i++) begin
      first_at[i] = -1;
      n_evt[i]    = 0;
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic hold(input logic lvl, input int n);
    btn_db = lvl;
    wait_neg(n);
  endtask

  // Leaves the bench at the negedge just before the first post-reset edge.
  task automatic do_reset(input logic lvl);
    @(negedge clock);
    #2;
    reset_n = 1'b0;
    btn_db  = lvl;
    #1;
    chk("rst_outs", int'(dut_vec), 0);
    clear_log();
    chk_en = 1'b1;
    wait_neg(2);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b1;
    btn_db  = 1'b0;
    chk_en  = 1'b0;
    clear_log();

    // Single short press: 20 cycles high.
    do_reset(1'b0);
    wait_neg(2);
    hold(1'b1, 20);
    hold(1'b0, 40);
    chk("s1_press_at", first_at[0], 3);
    chk("s1_release_at", first_at[1], 23);
    chk("s1_short_at", first_at[2], 42);
    chk("s1_short_n", n_evt[2], 1);
    chk("s1_long_n", n_evt[4], 0);

    // Two 8-cycle presses separated by 8 cycles.
    do_reset(1'b0);
    wait_neg(2);
    hold(1'b1, 8);
    hold(1'b0, 8);
    hold(1'b1, 8);
    hold(1'b0, 30);
    chk("s2_double_at", first_at[3], 19);
    chk("s2_double_n", n_evt[3], 1);
    chk("s2_short_n", n_evt[2], 0);
    chk("s2_press_n", n_evt[0], 2);

    // Long hold of 100 cycles with auto-repeat.
    do_reset(1'b0);
    wait_neg(2);
    hold(1'b1, 100);
    hold(1'b0, 30);
    chk("s3_long_at", first_at[4], 42);
    chk("s3_long_n", n_evt[4], 1);
    chk("s3_repeat_n", n_evt[5], 5);
    chk("s3_repeat_at", first_at[5], 54);
    chk("s3_release_at", first_at[1], 103);
    chk("s3_short_n", n_evt[2], 0);

    // Fall arrives in the same cycle the long threshold is reached.
    do_reset(1'b0);
    wait_neg(2);
    hold(1'b1, 39);
    hold(1'b0, 40);
    chk("s4_long_n", n_evt[4], 0);
    chk("s4_release_at", first_at[1], 42);
    chk("s4_short_at", first_at[2], 62);

    // Reset while waiting for a second click.
    do_reset(1'b0);
    wait_neg(2);
    hold(1'b1, 4);
    btn_db = 1'b0;
    @(negedge clock);
    chk("s5_release_before_rst", int'(release_pulse), 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("s5_rst_outs", int'(dut_vec), 0);
    clear_log();
    wait_neg(3);
    reset_n = 1'b1;
    wait_neg(40);
    chk("s5_short_n", n_evt[2], 0);
    chk("s5_press_n", n_evt[0], 0);

    // Button already down across reset release.
    do_reset(1'b1);
    hold(1'b1, 50);
    hold(1'b0, 20);
    chk("s6_press_at", first_at[0], 1);
    chk("s6_long_at", first_at[4], 42);
    chk("s6_repeat_n", n_evt[5], 0);
    chk("s6_release_at", first_at[1], 51);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/button_event.md
BUTTON_EVENT -- requirements
Module: button_event

Interface
REQ-001 Parameter TICK_DIV, default 50000, SHALL set clock cycles per 1 ms timebase tick (>=2).
REQ-002 Parameter LONG_MS, default 800, SHALL set hold time in ticks before a long press is declared.
REQ-003 Parameter DCLICK_MS, default 250, SHALL set the window in ticks for a second press to count as a double click.
REQ-004 Parameter REPEAT_MS, default 100, SHALL set the auto-repeat period in ticks while in long-press hold.
REQ-005 clock  in  1  SHALL be the sole clock; all logic on posedge.
REQ-006 reset_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-007 btn_db  in  1  SHALL be the debounced, clock-synchronous button level (1 = pressed).
REQ-008 held  out  1  SHALL be the registered copy of btn_db.
REQ-009 press / release  out  1 each  SHALL pulse one cycle per rising / falling edge of btn_db.
REQ-010 short_click, double_click, long_press, repeat  out  1 each  SHALL pulse one cycle per classified event.

Function
REQ-011 Edge detect: btn_prev <= btn_db each cycle; press = btn_db & ~btn_prev, release = ~btn_db & btn_prev, registered, so pulses appear 1 cycle after the input edge.
REQ-012 Tick generator: cycle counter 0..TICK_DIV-1, tick pulses on wrap; free-running, never cleared by the FSM.
REQ-013 ms counter: 16-bit, increments on tick, saturates at 0xFFFF, cleared to 0 on every FSM state change.
REQ-014 FSM states: IDLE, DOWN1, UP1, DOWN2, LONG.
REQ-015 IDLE: rise -> DOWN1.
REQ-016 DOWN1: fall -> UP1; else ms == LONG_MS -> LONG with long_press pulse.
REQ-017 UP1: rise -> DOWN2 with double_click pulse; else ms == DCLICK_MS -> IDLE with short_click pulse.
REQ-018 DOWN2: fall -> IDLE; no long_press or repeat from DOWN2.
REQ-019 LONG: each time ms reaches REPEAT_MS, pulse repeat and clear ms; fall -> IDLE, no further event.
REQ-020 Simultaneous edge and timeout in the same cycle: the edge transition SHALL win and the timeout event SHALL be suppressed.
REQ-021 Event outputs SHALL be registered, one cycle wide, mutually exclusive, and asserted the cycle after the transition-causing condition.
REQ-022 A rise in the same cycle as a tick-driven timeout SHALL see the edge evaluated first (REQ-020).

Reset
REQ-023 On reset_n low, all outputs SHALL be 0, FSM SHALL be IDLE, counters SHALL be 0, and btn_prev SHALL be 0 — immediately, without a clock.
REQ-024 Button held across reset release: the first cycle with btn_db=1 SHALL produce press and enter DOWN1.
REQ-025 Reset asserted mid-sequence SHALL discard any pending classification with no event output.

Structure
REQ-026 Package button_event_pkg SHALL hold the state enum typedef and the 16-bit ms counter width constant.
REQ-027 Sub-module button_tick_gen (parameter TICK_DIV; ports clock, reset_n, tick) SHALL implement REQ-012.

Verification (TICK_DIV=4, LONG_MS=10, DCLICK_MS=5, REPEAT_MS=3)
REQ-028 btn_db high 20 cycles then low -> press at +1, release 1 cycle after fall, short_click 5 ticks (~20 cycles) after release, no long_press.
REQ-029 Two 8-cycle presses 8 cycles apart -> double_click 1 cycle after the second rise; no short_click.
REQ-030 btn_db high 100 cycles -> long_press at ms=10 (~40 cycles), then repeat every 12 cycles (5 pulses), nothing on release.
REQ-031 Fall aligned with the tick making ms=LONG_MS -> UP1 entered, no long_press.
REQ-032 reset_n low during UP1 -> outputs 0 asynchronously; no short_click after release of reset.
REQ-033 btn_db high before and through reset deassertion -> press 1 cycle after first sampled clock, FSM in DOWN1.
